// File: rtl/lsu_bus_master.sv
// Load/store unit bridging a single-cycle RV32I core to a valid/ready request, rvalid response bus.
// Performs lane steering, sign/zero extension, legality checks and a response timeout.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        access_fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    lane_q, lane_d;

  logic          illegal;
  logic          tmo_hit;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  assign stall = (mem_read | mem_write) && (state_q != DONE);

  // Width code funct3[1:0] is shared by loads and stores: 00 byte, 01 half, 10 word.
  always_comb begin
    illegal = 1'b0;
    if (mem_read && mem_write) begin
      illegal = 1'b1;
    end else if (mem_read) begin
      if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
    end else if (mem_write) begin
      if (funct3[2] || funct3[1:0] == 2'b11) illegal = 1'b1;
    end
    if (funct3[1:0] == 2'b01 && addr[0]) illegal = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) illegal = 1'b1;
  end

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  // Fires on the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT_RSP.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + 1'b1) == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_read | mem_write) begin
          if (illegal) begin
            state_d = DONE;
            fault_d = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = REQ;
            valid_d = 1'b1;
            we_d    = mem_write;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
            f3_d    = funct3;
            lane_d  = addr[1:0];
            fault_d = 1'b0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (tmo_hit) begin
          state_d = DONE;
          valid_d = 1'b0;
          fault_d = 1'b1;
          rdata_d = 32'd0;
        end else if (bus_ready) begin
          state_d = WAIT_RSP;
          valid_d = 1'b0;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          state_d = DONE;
          fault_d = 1'b0;
          if (!we_q) rdata_d = load_ext;
        end else if (tmo_hit) begin
          state_d = DONE;
          fault_d = 1'b1;
          rdata_d = 32'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        fault_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
    end
  end

  assign bus_valid    = valid_q;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_be       = be_q;
  assign bus_wdata    = wdata_q;
  assign read_data    = rdata_q;
  assign access_fault = fault_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: loads, stores, back-pressure, illegal accesses, timeout, reset.
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, store_data = 32'd0;
  logic [31:0] read_data;
  logic        stall, access_fault;
  logic        bus_valid, bus_we;
  logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = 32'd0;
  logic [3:0]  bus_be;

  int tests_run = 0;
  int tests_failed = 0;

  lsu_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data),
    .read_data(read_data), .stall(stall), .access_fault(access_fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // One complete legal access; ready is withheld for 'delay' REQ cycles.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                            input int delay, input logic [31:0] rdata,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rd);
    int stalls;
    stalls = 0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    #1;
    stalls += int'(stall);
    check_eq($sformatf("%s_idle_valid", tag), 32'(bus_valid), 32'd0);
    @(posedge clk);
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      bus_ready = (i == delay);
      #1;
      stalls += int'(stall);
      check_eq($sformatf("%s_req%0d_valid", tag, i), 32'(bus_valid), 32'd1);
      check_eq($sformatf("%s_req%0d_addr", tag, i), bus_addr, {a[31:2], 2'b00});
      check_eq($sformatf("%s_req%0d_be", tag, i), 32'(bus_be), 32'(exp_be));
      check_eq($sformatf("%s_req%0d_we", tag, i), 32'(bus_we), 32'(wr));
      if (wr) check_eq($sformatf("%s_req%0d_wdata", tag, i), bus_wdata, exp_wdata);
    end
    @(posedge clk);
    @(negedge clk);
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = rdata;
    #1;
    stalls += int'(stall);
    check_eq($sformatf("%s_wait_valid", tag), 32'(bus_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    check_eq($sformatf("%s_done_stall", tag), 32'(stall), 32'd0);
    check_eq($sformatf("%s_done_rdata", tag), read_data, exp_rd);
    check_eq($sformatf("%s_done_fault", tag), 32'(access_fault), 32'd0);
    check_eq($sformatf("%s_stall_cycles", tag), 32'(stalls), 32'(3 + delay));
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic run_illegal(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
    #1;
    check_eq($sformatf("%s_idle_stall", tag), 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq($sformatf("%s_fault", tag), 32'(access_fault), 32'd1);
    check_eq($sformatf("%s_rdata", tag), read_data, 32'd0);
    check_eq($sformatf("%s_valid", tag), 32'(bus_valid), 32'd0);
    check_eq($sformatf("%s_stall", tag), 32'(stall), 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #1;
    check_eq("rst_valid", 32'(bus_valid), 32'd0);
    check_eq("rst_addr", bus_addr, 32'd0);
    check_eq("rst_rdata", read_data, 32'd0);
    check_eq("rst_fault", 32'(access_fault), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_access("lw",  1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    run_access("lb",  1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF1234, 4'b1000, 32'h0, 32'hFFFFFF80);
    run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FF1234, 4'b1000, 32'h0, 32'h00000080);
    run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 0, 32'h80FF1234, 4'b1100, 32'h0, 32'h000080FF);
    run_access("lh",  1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 0, 32'h80FF1234, 4'b1100, 32'h0, 32'hFFFF80FF);
    // Stores leave read_data at the previous load result.
    run_access("sb",  1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'hFFFF80FF);
    run_access("sh",  1'b0, 1'b1, 3'b001, 32'h302, 32'h00001234, 0, 32'h0, 4'b1100, 32'h12341234, 32'hFFFF80FF);
    run_access("sw_bp", 1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 5, 32'h0, 4'b1111, 32'hCAFEF00D, 32'hFFFF80FF);

    run_illegal("ill_lw", 1'b1, 1'b0, 3'b010, 32'h102);
    run_illegal("ill_lh", 1'b1, 1'b0, 3'b001, 32'h101);
    run_illegal("ill_f3", 1'b1, 1'b0, 3'b011, 32'h100);
    run_illegal("ill_rw", 1'b1, 1'b1, 3'b010, 32'h100);
    run_illegal("ill_sbu", 1'b0, 1'b1, 3'b100, 32'h100);

    run_access("lw2", 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0, 32'h13572468, 4'b1111, 32'h0, 32'h13572468);

    // Timeout: ready never comes; 8 cycles in REQ then DONE.
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check_eq($sformatf("tmo_req%0d_valid", i), 32'(bus_valid), 32'd1);
      check_eq($sformatf("tmo_req%0d_stall", i), 32'(stall), 32'd1);
      @(posedge clk);
    end
    @(negedge clk); #1;
    check_eq("tmo_fault", 32'(access_fault), 32'd1);
    check_eq("tmo_rdata", read_data, 32'd0);
    check_eq("tmo_valid", 32'(bus_valid), 32'd0);
    check_eq("tmo_stall", 32'(stall), 32'd0);
    mem_read = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
    @(negedge clk); #1;
    bus_rvalid = 1'b0;
    check_eq("late_rdata", read_data, 32'd0);
    check_eq("late_fault", 32'(access_fault), 32'd0);

    // Reset asserted while waiting for a response.
    run_access("lw3", 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 0, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b000; addr = 32'h701; bus_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_rdata", read_data, 32'd0);
    check_eq("rst_mid_addr", bus_addr, 32'd0);
    check_eq("rst_mid_be", 32'(bus_be), 32'd0);
    check_eq("rst_mid_valid", 32'(bus_valid), 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk); #1;
    bus_rvalid = 1'b0;
    check_eq("rst_late_rdata", read_data, 32'd0);
    check_eq("rst_late_fault", 32'(access_fault), 32'd0);
    check_eq("rst_idle_stall", 32'(stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store unit that services a single-cycle RV32I core's data-memory accesses over a valid/ready request, rvalid response bus.
- Produces the sign- or zero-extended `read_data` consumed by the writeback result selector.
- Holds the core with `stall` until the access completes.
- Handles byte/halfword lane steering, alignment/illegal checks and a response timeout.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles spent in REQ+WAIT_RSP before the access is abandoned as a fault; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  core requests load (held stable while stall=1)
- mem_write  in  1  core requests store (held stable while stall=1)
- funct3  in  3  RV32I load/store width/sign code
- addr  in  32  byte address from ALU
- store_data  in  32  rs2 value for stores
- read_data  out  32  extended load result, valid in DONE cycle
- stall  out  1  freeze PC/regfile write
- access_fault  out  1  misaligned, illegal funct3 or timeout; valid in DONE cycle
- bus_valid  out  1  request valid
- bus_ready  in  1  slave accepts request
- bus_we  out  1  1=write
- bus_addr  out  32  word-aligned address (addr[1:0] forced 00)
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rvalid  in  1  response (read data or write ack)
- bus_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; timeout counter=0.
  - bus_valid=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
  - read_data=0, access_fault=0.
  - Reset mid-transaction abandons it; a later bus_rvalid is ignored.
- States: IDLE, REQ, WAIT_RSP, DONE.
- `stall` is combinational: `(mem_read|mem_write) && state!=DONE`.
- IDLE with mem_read^mem_write and legal, aligned access:
  - Register bus_addr, bus_we, bus_be, bus_wdata.
  - Set bus_valid=1 and go to REQ.
- IDLE with illegal access goes straight to DONE with access_fault=1, read_data=0 and no bus traffic. Illegal means any of:
  - both mem_read and mem_write set;
  - loads with funct3 011, 110 or 111;
  - stores with funct3 other than 000/001/010;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=00.
- REQ:
  - bus_valid and all bus_* outputs are held stable until bus_ready=1.
  - On bus_ready: bus_valid=0 next cycle, go to WAIT_RSP.
  - bus_rvalid in REQ is ignored.
- WAIT_RSP:
  - On bus_rvalid (the earliest possible is the cycle after the handshake): if read, register the extracted result into read_data; access_fault=0; go to DONE.
  - On a write, read_data is unchanged.
- Timeout:
  - The counter increments each cycle in REQ/WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES: bus_valid=0, access_fault=1, read_data=0, go to DONE.
- DONE lasts exactly one cycle (stall=0, core advances), then IDLE; the counter clears.
- Minimum access: 4 cycles (IDLE, REQ with ready=1, WAIT_RSP with rvalid=1, DONE); stall high for 3 of them.
- Load extraction, lane = addr[1:0]:
  - LB (000) / LBU (100): byte at lane, sign- / zero-extended.
  - LH (001) / LHU (101): halfword at addr[1], sign- / zero-extended.
  - LW (010): whole word.
- Store steering:
  - SB: be = 0001 shifted left by lane; wdata = byte replicated ×4.
  - SH: be = 0011 or 1100; wdata = halfword replicated ×2.
  - SW: be = 1111; wdata = store_data.
- Loads drive bus_be with the same pattern as the equivalent store width.
- bus_rvalid arriving in IDLE or DONE (late or spurious) is dropped.

Test Plan:
- LW addr=0x100, slave ready immediately, rvalid next cycle with rdata=0xDEADBEEF → bus_addr=0x100, be=1111, stall high 3 cycles, DONE read_data=0xDEADBEEF, fault=0.
- LB addr=0x203, rdata=0x80FF_1234 → be=1000, read_data=0xFFFFFF80; LBU same → 0x00000080; LHU addr=0x202 → 0x000080FF.
- SB addr=0x301, store_data=0x000000A5 → bus_we=1, be=0010, wdata=0xA5A5A5A5; SH addr=0x302, store_data=0x1234 → be=1100, wdata=0x12341234.
- bus_ready held 0 for 5 cycles → bus_valid/addr/be/wdata stable all 5 cycles, stall stays 1, completes normally after ready.
- LW addr=0x102 or LH addr=0x101 or funct3=011 → DONE next cycle, access_fault=1, read_data=0, bus_valid never asserted.
- TIMEOUT_CYCLES=8 with no rvalid → DONE after 8 cycles in REQ/WAIT_RSP, fault=1, bus_valid=0; late rvalid ignored. rst_n pulsed low in WAIT_RSP → all outputs 0 immediately, state IDLE.
